// File: rtl/valu_seq.sv
// valu_seq: sequences one vector ALU instruction word-by-word through read, ALU and writeback stages
module valu_seq #(
  parameter int MICROOP_WIDTH = 5,
  parameter int VECTOR_LANES = 8,
  localparam int WI = $clog2(VECTOR_LANES),
  localparam int VLW = $clog2(4*VECTOR_LANES) + 1,
  localparam int MB = 4*VECTOR_LANES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     instr_valid_i,
  output logic                     instr_ready_o,
  input  logic [MICROOP_WIDTH-1:0] instr_microop_i,
  input  logic [1:0]               instr_vsew_i,
  input  logic [VLW-1:0]           instr_vl_i,
  input  logic                     instr_vm_i,
  input  logic [MB-1:0]            instr_mask_i,
  input  logic [4:0]               instr_vd_i,
  input  logic [4:0]               instr_vs1_i,
  input  logic [4:0]               instr_vs2_i,
  input  logic [31:0]              instr_imm_i,
  output logic [5+WI-1:0]          rd_addr_a_o,
  output logic [5+WI-1:0]          rd_addr_b_o,
  input  logic [31:0]              rd_data_a_i,
  input  logic [31:0]              rd_data_b_i,
  output logic                     alu_valid_o,
  output logic [31:0]              alu_data_a_o,
  output logic [31:0]              alu_data_b_o,
  output logic [31:0]              alu_imm_o,
  output logic [MICROOP_WIDTH-1:0] alu_microop_o,
  output logic [1:0]               alu_vsew_o,
  input  logic [31:0]              alu_result_i,
  output logic                     wb_valid_o,
  output logic [5+WI-1:0]          wb_addr_o,
  output logic [31:0]              wb_data_o,
  output logic [3:0]               wb_be_o,
  output logic                     scalar_valid_o,
  output logic [31:0]              scalar_data_o,
  output logic                     done_o
);
  localparam logic [MICROOP_WIDTH-1:0] VMV = MICROOP_WIDTH'(5'b01011);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [WI-1:0] w, s2_w;
  logic [WI:0] n, in_n;
  logic [MICROOP_WIDTH-1:0] op;
  logic [1:0] sew;
  logic [VLW-1:0] vl, vlmax, in_vl;
  logic [VLW:0] in_bytes;
  logic vm, in_vmv, in_skip, accept, rd_valid, rd_last, s2_last, s2_vmv;
  logic [MB-1:0] mask;
  logic [4:0] vd, vs1, vs2;
  logic [31:0] imm;
  logic [3:0] rd_be, s2_be;
  logic [WI+1:0] ei;
  assign vlmax = VLW'(MB) >> instr_vsew_i;
  assign in_vl = instr_vl_i < vlmax ? instr_vl_i : vlmax;
  assign in_bytes = (VLW+1)'(in_vl) << instr_vsew_i;
  assign in_n = (WI+1)'((in_bytes + (VLW+1)'(3)) >> 2);
  assign in_vmv = instr_microop_i == VMV;
  assign in_skip = instr_vsew_i == 2'b11 || (!in_vmv && in_n == '0);
  assign accept = state == IDLE && instr_valid_i && !flush_i;
  assign instr_ready_o = state == IDLE;
  assign rd_valid = state == RUN;
  assign rd_last = ({1'b0, w} + (WI+1)'(1)) == n;
  assign rd_addr_a_o = {vs1, w};
  assign rd_addr_b_o = {vs2, w};
  assign alu_data_a_o = alu_valid_o ? rd_data_a_i : '0;
  assign alu_data_b_o = alu_valid_o ? rd_data_b_i : '0;
  assign s2_vmv = alu_microop_o == VMV;
  // byte enables of the word being read: element index per byte lane, gated by vl and mask
  always_comb begin
    rd_be = '0;
    ei = '0;
    for (int b = 0; b < 4; b++) begin
      ei = sew == 2'b00 ? {w, 2'(b)} : sew == 2'b01 ? {1'b0, w, 1'(b/2)} : {2'b00, w};
      rd_be[b] = ({1'b0, ei} < vl) && (vm || mask[ei]);
    end
  end
  // control FSM: latch instruction, walk word index, wait for the final writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      w <= '0;
      n <= '0;
      op <= '0;
      sew <= '0;
      vl <= '0;
      vm <= 1'b0;
      mask <= '0;
      vd <= '0;
      vs1 <= '0;
      vs2 <= '0;
      imm <= '0;
    end else if (flush_i) begin
      state <= IDLE;
      w <= '0;
    end else begin
      case (state)
        IDLE: if (instr_valid_i) begin
          op <= instr_microop_i;
          sew <= instr_vsew_i;
          vl <= in_vl;
          vm <= instr_vm_i;
          mask <= instr_mask_i;
          vd <= instr_vd_i;
          vs1 <= instr_vs1_i;
          vs2 <= instr_vs2_i;
          imm <= instr_imm_i;
          n <= in_vmv ? (WI+1)'(1) : in_n;
          w <= '0;
          state <= in_skip ? DRAIN : RUN;
        end
        RUN: begin
          w <= w + WI'(1);
          state <= rd_last ? DRAIN : RUN;
        end
        DRAIN: state <= done_o ? IDLE : DRAIN;
        default: state <= IDLE;
      endcase
    end
  end
  // ALU and writeback pipeline stages; a flush empties both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid_o <= 1'b0;
      alu_microop_o <= '0;
      alu_vsew_o <= '0;
      alu_imm_o <= '0;
      s2_w <= '0;
      s2_be <= '0;
      s2_last <= 1'b0;
      wb_valid_o <= 1'b0;
      wb_addr_o <= '0;
      wb_data_o <= '0;
      wb_be_o <= '0;
      scalar_valid_o <= 1'b0;
      scalar_data_o <= '0;
      done_o <= 1'b0;
    end else if (flush_i) begin
      alu_valid_o <= 1'b0;
      wb_valid_o <= 1'b0;
      scalar_valid_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      alu_valid_o <= rd_valid;
      alu_microop_o <= op;
      alu_vsew_o <= sew;
      alu_imm_o <= imm;
      s2_w <= w;
      s2_be <= rd_be;
      s2_last <= rd_last;
      wb_valid_o <= alu_valid_o && !s2_vmv && s2_be != 4'b0000;
      wb_addr_o <= {vd, s2_w};
      wb_data_o <= alu_result_i;
      wb_be_o <= s2_be;
      scalar_valid_o <= alu_valid_o && s2_vmv;
      scalar_data_o <= alu_valid_o && s2_vmv ? alu_result_i : scalar_data_o;
      done_o <= (accept && in_skip) || (alu_valid_o && s2_last);
    end
  end
endmodule
